// File: rtl/execute_stage_p.sv
// rtl/execute_stage_p.sv - RV32-style execute stage: D/E register, forwarding, ALU, branch and JALR resolution.
// Define EXEC_MUL_EN to build the iterative shift-add multiplier that holds the stage through BusyE.
module execute_stage_p #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              StallE,
  input  logic              FlushE,
  input  logic              RegWriteD,
  input  logic              MemWriteD,
  input  logic              JumpD,
  input  logic              BranchD,
  input  logic              JALRD,
  input  logic              ALUSrcD,
  input  logic              MulD,
  input  logic [1:0]        ResultSrcD,
  input  logic [3:0]        ALUControlD,
  input  logic [2:0]        BranchCondD,
  input  logic [WIDTH-1:0]  RD1D,
  input  logic [WIDTH-1:0]  RD2D,
  input  logic [WIDTH-1:0]  PCD,
  input  logic [WIDTH-1:0]  ImmExtD,
  input  logic [WIDTH-1:0]  PCPlus4D,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] RdD,
  input  logic [1:0]        ForwardAE,
  input  logic [1:0]        ForwardBE,
  input  logic [WIDTH-1:0]  ALUResultM,
  input  logic [WIDTH-1:0]  ResultW,
  output logic              RegWriteE,
  output logic              MemWriteE,
  output logic              PCSrcE,
  output logic [1:0]        ResultSrcE,
  output logic [WIDTH-1:0]  ALUResultE,
  output logic [WIDTH-1:0]  WriteDataE,
  output logic [WIDTH-1:0]  PCTargetE,
  output logic [WIDTH-1:0]  PCPlus4E,
  output logic [REG_AW-1:0] Rs1E,
  output logic [REG_AW-1:0] Rs2E,
  output logic [REG_AW-1:0] RdE,
  output logic              BusyE
);

  localparam int SHW = $clog2(WIDTH);

  typedef struct packed {
    logic              reg_write;
    logic              mem_write;
    logic              jump;
    logic              branch;
    logic              jalr;
    logic              alu_src;
`ifdef EXEC_MUL_EN
    logic              mul;
`endif
    logic [1:0]        result_src;
    logic [3:0]        alu_control;
    logic [2:0]        branch_cond;
    logic [WIDTH-1:0]  rd1;
    logic [WIDTH-1:0]  rd2;
    logic [WIDTH-1:0]  pc;
    logic [WIDTH-1:0]  imm;
    logic [WIDTH-1:0]  pc_plus4;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
  } de_t;

  de_t              de_q, de_d;
  logic             busy;
  logic [WIDTH-1:0] src_a, rs2_fwd, src_b;
  logic [WIDTH-1:0] alu_result, jalr_sum;
  logic [SHW-1:0]   shamt;
  logic             lt_s, lt_u, eq, taken;

  always_comb begin
    de_d             = '0;
    de_d.reg_write   = RegWriteD;
    de_d.mem_write   = MemWriteD;
    de_d.jump        = JumpD;
    de_d.branch      = BranchD;
    de_d.jalr        = JALRD;
    de_d.alu_src     = ALUSrcD;
`ifdef EXEC_MUL_EN
    de_d.mul         = MulD;
`endif
    de_d.result_src  = ResultSrcD;
    de_d.alu_control = ALUControlD;
    de_d.branch_cond = BranchCondD;
    de_d.rd1         = RD1D;
    de_d.rd2         = RD2D;
    de_d.pc          = PCD;
    de_d.imm         = ImmExtD;
    de_d.pc_plus4    = PCPlus4D;
    de_d.rs1         = Rs1D;
    de_d.rs2         = Rs2D;
    de_d.rd          = RdD;
  end

  // A multiply in flight holds the register exactly like an upstream stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_q <= '0;
    end else if (FlushE) begin
      de_q <= '0;
    end else if (!(StallE || busy)) begin
      de_q <= de_d;
    end
  end

  always_comb begin
    case (ForwardAE)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = ALUResultM;
      default: src_a = de_q.rd1;
    endcase
    case (ForwardBE)
      2'b01:   rs2_fwd = ResultW;
      2'b10:   rs2_fwd = ALUResultM;
      default: rs2_fwd = de_q.rd2;
    endcase
  end

  assign src_b = de_q.alu_src ? de_q.imm : rs2_fwd;
  assign shamt = src_b[SHW-1:0];
  assign lt_s  = $signed(src_a) < $signed(src_b);
  assign lt_u  = src_a < src_b;

  always_comb begin
    case (de_q.alu_control)
      4'b0000: alu_result = src_a + src_b;
      4'b0001: alu_result = src_a - src_b;
      4'b0010: alu_result = src_a & src_b;
      4'b0011: alu_result = src_a | src_b;
      4'b0100: alu_result = src_a ^ src_b;
      4'b0101: alu_result = {{(WIDTH-1){1'b0}}, lt_s};
      4'b0110: alu_result = {{(WIDTH-1){1'b0}}, lt_u};
      4'b0111: alu_result = src_a << shamt;
      4'b1000: alu_result = src_a >> shamt;
      4'b1001: alu_result = $unsigned($signed(src_a) >>> shamt);
      4'b1010: alu_result = src_b;
      default: alu_result = '0;
    endcase
  end

  // Branches always compare the two register operands, never the immediate.
  always_comb begin
    eq = (src_a == rs2_fwd);
    case (de_q.branch_cond)
      3'b000:  taken = eq;
      3'b001:  taken = !eq;
      3'b100:  taken = $signed(src_a) < $signed(rs2_fwd);
      3'b101:  taken = !($signed(src_a) < $signed(rs2_fwd));
      3'b110:  taken = src_a < rs2_fwd;
      3'b111:  taken = !(src_a < rs2_fwd);
      default: taken = 1'b0;
    endcase
  end

  assign jalr_sum = src_a + de_q.imm;

`ifdef EXEC_MUL_EN
  logic [SHW-1:0]   mul_cnt_q;
  logic             mul_active_q, mul_done_q;
  logic [WIDTH-1:0] mul_acc_q, mul_mcand_q, mul_mplier_q;
  logic [WIDTH-1:0] step_a, step_b, step_acc;

  // The first step consumes the live forwarded operands; later steps use the captured copies.
  assign busy     = de_q.mul & ~mul_done_q;
  assign step_a   = mul_active_q ? mul_mcand_q : src_a;
  assign step_b   = mul_active_q ? mul_mplier_q : src_b;
  assign step_acc = (mul_active_q ? mul_acc_q : '0) + (step_b[0] ? step_a : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_cnt_q    <= '0;
      mul_active_q <= 1'b0;
      mul_done_q   <= 1'b0;
      mul_acc_q    <= '0;
      mul_mcand_q  <= '0;
      mul_mplier_q <= '0;
    end else if (FlushE) begin
      mul_cnt_q    <= '0;
      mul_active_q <= 1'b0;
      mul_done_q   <= 1'b0;
      mul_acc_q    <= '0;
    end else if (busy) begin
      mul_acc_q    <= step_acc;
      mul_mcand_q  <= step_a << 1;
      mul_mplier_q <= step_b >> 1;
      if (mul_cnt_q == SHW'(WIDTH - 1)) begin
        mul_cnt_q    <= '0;
        mul_active_q <= 1'b0;
        mul_done_q   <= 1'b1;
      end else begin
        mul_cnt_q    <= mul_cnt_q + SHW'(1);
        mul_active_q <= 1'b1;
      end
    end else if (!StallE) begin
      mul_cnt_q    <= '0;
      mul_active_q <= 1'b0;
      mul_done_q   <= 1'b0;
    end
  end

  assign ALUResultE = de_q.mul ? mul_acc_q : alu_result;
`else
  logic unused_muld;
  assign unused_muld = MulD;
  assign busy        = 1'b0;
  assign ALUResultE  = alu_result;
`endif

  assign BusyE      = busy;
  assign RegWriteE  = de_q.reg_write & ~busy;
  assign MemWriteE  = de_q.mem_write & ~busy;
  assign PCSrcE     = (de_q.jump | (de_q.branch & taken)) & ~busy;
  assign ResultSrcE = de_q.result_src;
  assign WriteDataE = rs2_fwd;
  assign PCTargetE  = de_q.jalr ? {jalr_sum[WIDTH-1:1], 1'b0} : de_q.pc + de_q.imm;
  assign PCPlus4E   = de_q.pc_plus4;
  assign Rs1E       = de_q.rs1;
  assign Rs2E       = de_q.rs2;
  assign RdE        = de_q.rd;

endmodule

// File: tb/tb_execute_stage_p.sv
// tb/tb_execute_stage_p.sv - scoreboard bench for execute_stage_p; multiply vectors build only with EXEC_MUL_EN.
`timescale 1ns/1ps
module tb_execute_stage_p;
  localparam int W  = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, StallE, FlushE;
  logic RegWriteD, MemWriteD, JumpD, BranchD, JALRD, ALUSrcD, MulD;
  logic [1:0] ResultSrcD, ForwardAE, ForwardBE;
  logic [3:0] ALUControlD;
  logic [2:0] BranchCondD;
  logic [W-1:0] RD1D, RD2D, PCD, ImmExtD, PCPlus4D, ALUResultM, ResultW;
  logic [AW-1:0] Rs1D, Rs2D, RdD;
  logic RegWriteE, MemWriteE, PCSrcE, BusyE;
  logic [1:0] ResultSrcE;
  logic [W-1:0] ALUResultE, WriteDataE, PCTargetE, PCPlus4E;
  logic [AW-1:0] Rs1E, Rs2E, RdE;

  execute_stage_p #(.WIDTH(W), .REG_AW(AW)) dut (
    .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .BranchD(BranchD),
    .JALRD(JALRD), .ALUSrcD(ALUSrcD), .MulD(MulD), .ResultSrcD(ResultSrcD),
    .ALUControlD(ALUControlD), .BranchCondD(BranchCondD),
    .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .ImmExtD(ImmExtD), .PCPlus4D(PCPlus4D),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ALUResultM(ALUResultM), .ResultW(ResultW),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .PCSrcE(PCSrcE), .ResultSrcE(ResultSrcE),
    .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .PCTargetE(PCTargetE), .PCPlus4E(PCPlus4E),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .BusyE(BusyE)
  );

  typedef struct {
    logic rw, mw, jmp, br, jalr, src, mul;
    logic [1:0] rsrc, fa, fb;
    logic [3:0] ctl;
    logic [2:0] cond;
    logic [W-1:0] rd1, rd2, pc, imm, pc4, alum, resw;
    logic [AW-1:0] rs1, rs2, rd;
  } instr_t;

  typedef struct {
    string tag;
    logic [W-1:0] alu;
    logic pcsrc;
    logic [W-1:0] tgt;
    logic rw, mw;
    logic [W-1:0] wd;
  } exp_t;

  exp_t sb[$];
  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic instr_t nop();
    instr_t i;
    i = '{default: '0};
    return i;
  endfunction

  function automatic exp_t mk(input string tag, input logic [W-1:0] alu, input logic pcsrc,
                              input logic [W-1:0] tgt, input logic rw, input logic mw,
                              input logic [W-1:0] wd);
    exp_t e;
    e.tag = tag; e.alu = alu; e.pcsrc = pcsrc; e.tgt = tgt; e.rw = rw; e.mw = mw; e.wd = wd;
    return e;
  endfunction

  task automatic drive_d(input instr_t i);
    RegWriteD = i.rw; MemWriteD = i.mw; JumpD = i.jmp; BranchD = i.br; JALRD = i.jalr;
    ALUSrcD = i.src; MulD = i.mul; ResultSrcD = i.rsrc; ALUControlD = i.ctl; BranchCondD = i.cond;
    RD1D = i.rd1; RD2D = i.rd2; PCD = i.pc; ImmExtD = i.imm; PCPlus4D = i.pc4;
    Rs1D = i.rs1; Rs2D = i.rs2; RdD = i.rd;
  endtask

  task automatic set_fwd(input instr_t i);
    ForwardAE = i.fa; ForwardBE = i.fb; ALUResultM = i.alum; ResultW = i.resw;
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 1, 0);
    end else begin
      e = sb.pop_front();
      check({e.tag, ".alu"}, ALUResultE, e.alu);
      check({e.tag, ".pcsrc"}, PCSrcE, e.pcsrc);
      check({e.tag, ".tgt"}, PCTargetE, e.tgt);
      check({e.tag, ".rw"}, RegWriteE, e.rw);
      check({e.tag, ".mw"}, MemWriteE, e.mw);
      check({e.tag, ".wd"}, WriteDataE, e.wd);
    end
  endtask

  task automatic run(input instr_t i, input exp_t e);
    drive_d(i);
    sb.push_back(e);
    @(posedge clk); #1;
    set_fwd(i);
    @(negedge clk);
    compare_out();
  endtask

`ifdef EXEC_MUL_EN
  task automatic mul_test(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int abort_at, input bit stall_done, input instr_t nxt, input exp_t nxt_e);
    instr_t m;
    logic [W-1:0] prod;
    bit aborted;
    m = nop(); m.mul = 1; m.rw = 1; m.rd1 = a; m.rd2 = b; m.rd = 5'd7;
    prod = a * b;
    aborted = 0;
    drive_d(m);
    @(posedge clk); #1;
    set_fwd(nop());
    drive_d(nxt);
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      check({tag, ".busy"}, BusyE, 1);
      check({tag, ".rw_busy"}, RegWriteE, 0);
      if (k == abort_at) begin
        FlushE = 1;
        aborted = 1;
        break;
      end
      @(posedge clk); #1;
      if (k == 0) begin
        ForwardAE = 2'b10; ForwardBE = 2'b10; ALUResultM = '1;
      end
    end
    if (aborted) begin
      @(posedge clk); #1;
      FlushE = 0;
      set_fwd(nop());
      @(negedge clk);
      check({tag, ".abort_busy"}, BusyE, 0);
      check({tag, ".abort_rw"}, RegWriteE, 0);
      check({tag, ".abort_alu"}, ALUResultE, 0);
    end else begin
      set_fwd(nop());
      @(negedge clk);
      check({tag, ".done_busy"}, BusyE, 0);
      check({tag, ".done_alu"}, ALUResultE, prod);
      check({tag, ".done_rw"}, RegWriteE, 1);
      if (stall_done) begin
        StallE = 1;
        @(posedge clk); #1;
        StallE = 0;
        @(negedge clk);
        check({tag, ".hold_busy"}, BusyE, 0);
        check({tag, ".hold_alu"}, ALUResultE, prod);
      end
    end
    sb.push_back(nxt_e);
    @(posedge clk); #1;
    @(negedge clk);
    compare_out();
  endtask
`endif

  instr_t i;

  initial begin
    rst = 1; StallE = 0; FlushE = 0;
    drive_d(nop()); set_fwd(nop());
    #2;
    check("rst.alu", ALUResultE, 0);
    check("rst.busy", BusyE, 0);
    check("rst.pcsrc", PCSrcE, 0);
    repeat (2) @(negedge clk);
    rst = 0;

    i = nop(); i.rw = 1; i.rd1 = 5; i.rd2 = 32'hFFFF_FFFF; i.rd = 3; i.pc4 = 32'h44; i.rsrc = 2'b01;
    run(i, mk("add", 4, 0, 0, 1, 0, 32'hFFFF_FFFF));
    check("add.rd", RdE, 3);
    check("add.pc4", PCPlus4E, 32'h44);
    check("add.rsrc", ResultSrcE, 2'b01);
    i.fa = 2'b10; i.alum = 7;
    run(i, mk("add_fwdM", 6, 0, 0, 1, 0, 32'hFFFF_FFFF));
    i = nop(); i.rd1 = 0; i.rd2 = 1; i.ctl = 4'b0001;
    run(i, mk("sub_wrap", 32'hFFFF_FFFF, 0, 0, 0, 0, 1));

    i = nop(); i.br = 1; i.ctl = 4'b0001; i.rd1 = 32'hFFFF_FFFE; i.rd2 = 1; i.pc = 32'h100; i.imm = 32'h20;
    i.cond = 3'b100;
    run(i, mk("blt", 32'hFFFF_FFFD, 1, 32'h120, 0, 0, 1));
    i.cond = 3'b110;
    run(i, mk("bltu", 32'hFFFF_FFFD, 0, 32'h120, 0, 0, 1));
    i.cond = 3'b111; i.rd1 = 1; i.rd2 = 32'hFFFF_FFFF;
    run(i, mk("bgeu", 2, 0, 32'h120, 0, 0, 32'hFFFF_FFFF));
    i.cond = 3'b001;
    run(i, mk("bne", 2, 1, 32'h120, 0, 0, 32'hFFFF_FFFF));
    i.rd1 = 7; i.rd2 = 7; i.cond = 3'b101;
    run(i, mk("bge_eq", 0, 1, 32'h120, 0, 0, 7));
    i.cond = 3'b000;
    run(i, mk("beq", 0, 1, 32'h120, 0, 0, 7));
    i.cond = 3'b010;
    run(i, mk("cond010", 0, 0, 32'h120, 0, 0, 7));

    i = nop(); i.jmp = 1; i.jalr = 1; i.src = 1; i.rw = 1; i.rd1 = 32'h1003; i.imm = 4; i.pc = 32'h500;
    run(i, mk("jalr", 32'h1007, 1, 32'h1006, 1, 0, 0));
    FlushE = 1;
    i = nop(); i.rw = 1; i.mw = 1; i.jmp = 1; i.rd1 = 9; i.imm = 8; i.pc = 32'h40;
    drive_d(i);
    sb.push_back(mk("flush", 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    FlushE = 0;
    set_fwd(nop());
    drive_d(nop());
    @(negedge clk);
    compare_out();

    i = nop(); i.ctl = 4'b1001; i.rd1 = 32'h8000_0000; i.rd2 = 4;
    run(i, mk("sra", 32'hF800_0000, 0, 0, 0, 0, 4));
    i.ctl = 4'b1000;
    run(i, mk("srl", 32'h0800_0000, 0, 0, 0, 0, 4));
    i.ctl = 4'b0111; i.rd1 = 1; i.rd2 = 32'h21;
    run(i, mk("sll_wrapamt", 2, 0, 0, 0, 0, 32'h21));
    i.ctl = 4'b0101; i.rd1 = 32'hFFFF_FFFF; i.rd2 = 1;
    run(i, mk("slt", 1, 0, 0, 0, 0, 1));
    i.ctl = 4'b0110;
    run(i, mk("sltu", 0, 0, 0, 0, 0, 1));
    i.ctl = 4'b1011; i.rd1 = 3; i.rd2 = 4;
    run(i, mk("op1011", 0, 0, 0, 0, 0, 4));
    i.ctl = 4'b1111;
    run(i, mk("op1111", 0, 0, 0, 0, 0, 4));
    i = nop(); i.ctl = 4'b1010; i.src = 1; i.imm = 32'hABC; i.rd2 = 32'h55;
    run(i, mk("passb", 32'hABC, 0, 32'hABC, 0, 0, 32'h55));

    i = nop(); i.ctl = 4'b0010; i.rd1 = 32'hFF; i.rd2 = 32'h10; i.fb = 2'b11; i.resw = 32'h99; i.alum = 32'h77;
    run(i, mk("fwdB_rsvd", 32'h10, 0, 0, 0, 0, 32'h10));
    i.fb = 2'b01;
    run(i, mk("fwdB_W", 32'h99, 0, 0, 0, 0, 32'h99));
    i.fb = 2'b10; i.ctl = 4'b0011; i.rd1 = 32'h100;
    run(i, mk("fwdB_M", 32'h177, 0, 0, 0, 0, 32'h77));
    i = nop(); i.mw = 1; i.src = 1; i.rd1 = 32'h1000; i.imm = 8; i.rd2 = 32'hDEAD;
    run(i, mk("store", 32'h1008, 0, 8, 0, 1, 32'hDEAD));

    i = nop(); i.rw = 1; i.rd1 = 2; i.rd2 = 3;
    run(i, mk("stall_a", 5, 0, 0, 1, 0, 3));
    StallE = 1;
    i.rd1 = 10; i.rd2 = 10;
    run(i, mk("stall_hold", 5, 0, 0, 1, 0, 3));
    StallE = 0;
    run(i, mk("stall_b", 20, 0, 0, 1, 0, 10));

`ifdef EXEC_MUL_EN
    i = nop(); i.rw = 1; i.rd1 = 2; i.rd2 = 3;
    mul_test("mul", 32'h1234, 32'h10, -1, 0, i, mk("after_mul", 5, 0, 0, 1, 0, 3));
    mul_test("mul_stall", 32'h3, 32'h5, -1, 1, i, mk("after_mul_stall", 5, 0, 0, 1, 0, 3));
    mul_test("mul_abort", 32'h7, 32'h9, 10, 0, i, mk("after_abort", 5, 0, 0, 1, 0, 3));
    mul_test("mul_big", 32'hFFFF_FFFF, 32'h8000_0001, -1, 0, i, mk("after_mul_big", 5, 0, 0, 1, 0, 3));
`endif

    i = nop(); i.rw = 1; i.mw = 1; i.jmp = 1; i.rd1 = 32'h30; i.rd2 = 32'h9; i.imm = 32'h10;
    i.pc = 32'h200; i.pc4 = 32'h204; i.rd = 9;
    run(i, mk("pre_rst", 32'h39, 1, 32'h210, 1, 1, 32'h9));
    drive_d(nop());
    set_fwd(nop());
    #2 rst = 1;
    #1;
    check("arst.alu", ALUResultE, 0);
    check("arst.tgt", PCTargetE, 0);
    check("arst.pcsrc", PCSrcE, 0);
    check("arst.rw", RegWriteE, 0);
    check("arst.mw", MemWriteE, 0);
    check("arst.busy", BusyE, 0);
    check("arst.rd", RdE, 0);
    check("arst.pc4", PCPlus4E, 0);
    check("arst.wd", WriteDataE, 0);
    #1 rst = 0;
    check("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
